// File: rtl/peres_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : peres_inv_pipe
// Description : Two-stage valid/ready streaming inverse of the Peres gate.
//               Recovers A=P, B=P^Q, C=R^(A&B) bitwise across WIDTH lanes.
//               Optional output word counter enabled by PERES_INV_CNT_EN;
//               with the macro undefined word_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module peres_inv_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_q,
    input  logic [WIDTH-1:0] in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [CNT_W-1:0] word_cnt
);

    logic             s1_v;
    logic             s2_v;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_r;
    logic             s1_adv;
    logic             s2_adv;

    // A stage may load when it is empty or its contents move on this edge.
    // in_ready is therefore a combinational path from out_ready.
    assign s2_adv    = ~s2_v | out_ready;
    assign s1_adv    = ~s1_v | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;

    // Stage 1: capture A and B directly; keep R raw so C is formed next stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
            s1_r <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_a <= in_p;
                s1_b <= in_p ^ in_q;
                s1_r <= in_r;
            end
        end
    end

    // Stage 2: output register; data holds when empty or stalled by the sink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v  <= 1'b0;
            out_a <= '0;
            out_b <= '0;
            out_c <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_a <= s1_a;
                out_b <= s1_b;
                out_c <= s1_r ^ (s1_a & s1_b);
            end
        end
    end

`ifdef PERES_INV_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Count completed output handshakes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (s2_v && out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign word_cnt = cnt;
`else
    assign word_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_peres_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_peres_inv_pipe
// Description : Self-checking bench for peres_inv_pipe. Words are encoded
//               through a Peres model; the original (A,B,C) is queued on each
//               input handshake and compared on each output handshake.
//               A second instance with CNT_W=4 checks counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peres_inv_pipe;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_p, in_q, in_r;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_a, out_b, out_c;
    logic [CNT_W-1:0] word_cnt;

    logic               in_ready_s, out_valid_s;
    logic [WIDTH-1:0]   out_a_s, out_b_s, out_c_s;
    logic [CNT_W_S-1:0] word_cnt_s;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [3*WIDTH-1:0] sb[$];
    logic [WIDTH-1:0]   cur_a, cur_b, cur_c;

    peres_inv_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .in_q(in_q), .in_r(in_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .word_cnt(word_cnt)
    );

    peres_inv_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_p(in_p), .in_q(in_q), .in_r(in_r),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_a(out_a_s), .out_b(out_b_s), .out_c(out_c_s), .word_cnt(word_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n, input int w);
`ifdef PERES_INV_CNT_EN
        return 32'(n % (1 << w));
`else
        return 32'(0 * n * w);
`endif
    endfunction

    // Peres encode of the original operands onto the DUT inputs.
    task automatic set_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c);
        cur_a = a; cur_b = b; cur_c = c;
        in_p  = a;
        in_q  = a ^ b;
        in_r  = c ^ (a & b);
    endtask

    // Offer one word and wait (bounded) for it to be accepted.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c);
        logic acc;
        acc = 1'b0;
        set_word(a, b, c);
        in_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base, stalls, idx, unstable;
        logic acc;
        logic drv_done;
        logic [WIDTH-1:0] bp_a[5], bp_b[5], bp_c[5];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_p = '0; in_q = '0; in_r = '0;
        cur_a = '0; cur_b = '0; cur_c = '0;
        drv_done = 1'b0;

        // Scoreboard monitor: sample handshakes mid-cycle, act at next edge.
        fork
            forever begin
                logic [3*WIDTH-1:0] e;
                @(negedge clk);
                if (rst) begin
                    sb.delete();
                    hs_count = 0;
                end else begin
                    if (in_valid && in_ready) sb.push_back({cur_a, cur_b, cur_c});
                    if (out_valid && out_ready) begin
                        hs_count++;
                        if (sb.size() == 0) begin
                            check("sb_underflow", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            check("sb_data", 32'({out_a, out_b, out_c}), 32'(e));
                        end
                    end
                end
            end
        join_none

        // Power-on reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_word_cnt_s", 32'(word_cnt_s), 32'd0);
        check("rst_out_abc", 32'({out_a, out_b, out_c}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single word: P=1100 Q=0110 R=1110 -> A=1100 B=1010 C=0110
        out_ready = 1'b1;
        send(4'b1100, 4'b1010, 4'b0110);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_a", 32'(out_a), 32'b1100);
        check("single_b", 32'(out_b), 32'b1010);
        check("single_c", 32'(out_c), 32'b0110);
        @(posedge clk); #1;
        check("single_valid_off", 32'(out_valid), 32'd0);
        check("single_cnt", 32'(word_cnt), cnt_exp(1, CNT_W));

        // Exhaustive round trip, back-to-back
        base = hs_count; stalls = 0;
        for (int i = 0; i < 4096; i++) begin
            set_word(i[11:8], i[7:4], i[3:0]);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rt_stalls", 32'(stalls), 32'd0);
        check("rt_delivered", 32'(hs_count - base), 32'd4096);
        check("rt_sb_empty", 32'(sb.size()), 32'd0);
        check("rt_cnt", 32'(word_cnt), cnt_exp(4097, CNT_W));

        // Backpressure: sink stalled for 6 cycles with 5 words offered
        bp_a = '{4'h3, 4'h9, 4'hE, 4'h5, 4'h0};
        bp_b = '{4'hA, 4'h6, 4'h1, 4'hF, 4'h7};
        bp_c = '{4'hC, 4'h2, 4'h8, 4'h4, 4'hB};
        base = hs_count; idx = 0; unstable = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (idx < 5) set_word(bp_a[idx], bp_b[idx], bp_c[idx]);
            in_valid = (idx < 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (cyc >= 2 && {out_a, out_b, out_c} != {bp_a[0], bp_b[0], bp_c[0]}) unstable++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_stable", 32'(unstable), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 50 && idx < 5; k++) begin
            send(bp_a[idx], bp_b[idx], bp_c[idx]);
            idx++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_delivered", 32'(hs_count - base), 32'd5);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with the pipe full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_word(4'h1, 4'h2, 4'h3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_word_cnt", 32'(word_cnt), 32'd0);
        check("midrst_word_cnt_s", 32'(word_cnt_s), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);

        // 17 words: small counter wraps to 1
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++)
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("wrap_delivered", 32'(hs_count), 32'd17);
        check("wrap_cnt_s", 32'(word_cnt_s), cnt_exp(17, CNT_W_S));
        check("wrap_cnt", 32'(word_cnt), cnt_exp(17, CNT_W));

        // Random valid/ready toggling, 10k words
        base = hs_count;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("rand_sb_empty", 32'(sb.size()), 32'd0);
        check("rand_delivered", 32'(hs_count - base), 32'd10000);
        check("rand_cnt", 32'(word_cnt), cnt_exp(hs_count, CNT_W));
        check("rand_cnt_s", 32'(word_cnt_s), cnt_exp(hs_count, CNT_W_S));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
